// File: rtl/gc_init_loader.sv
// Global-controller initializer: captures selector, IC, restart, program-block,
// IC-select and iteration-variable words from the shared configuration bus.
module gc_init_loader #(
  parameter int DIMENSION                = 3,
  parameter int IVAR_WIDTH               = 16,
  parameter int BUS_WIDTH                = 16,
  parameter int SELECT_WIDTH             = 3,
  parameter int SELECT_ID                = 2,
  parameter int MAX_NO_OF_PROGRAM_BLOCKS = 12,
  parameter int NUM_OF_IC_SIGNALS        = 3
) (
  input  logic                                 conf_clk,
  input  logic                                 reset,
  input  logic [BUS_WIDTH-1:0]                 conf_bus,
  input  logic                                 conf_valid,
  input  logic [SELECT_WIDTH-1:0]              sel,
  input  logic                                 rearm,
  output logic                                 conf_ack,
  output logic                                 conf_error,
  output logic                                 busy,
  output logic [0:DIMENSION*IVAR_WIDTH-1]      init_ivar,
  output logic [0:NUM_OF_IC_SIGNALS-1]         init_ic,
  output logic [DIMENSION-1:0]                 output_selector,
  output logic                                 restart_mode,
  output logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0]  pb_selector,
  output logic [NUM_OF_IC_SIGNALS-1:0]         ic_selector
);

  localparam int PB_WORDS   = (MAX_NO_OF_PROGRAM_BLOCKS + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int IVAR_WORDS = (IVAR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int PBW_W      = (PB_WORDS > 1) ? $clog2(PB_WORDS) : 1;
  localparam int IVP_W      = (IVAR_WORDS > 1) ? $clog2(IVAR_WORDS) : 1;
  localparam int K_W        = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam int N_W        = $clog2(DIMENSION + 1);

  typedef enum logic [2:0] {
    S_OSEL, S_IC, S_RST, S_PB, S_ICSEL, S_IVAR, S_DONE
  } state_t;

  state_t                               state_q;
  logic [PBW_W-1:0]                     pbw_q;
  logic [IVP_W-1:0]                     ivp_q;
  logic [K_W-1:0]                       ivk_q;
  logic [N_W-1:0]                       n_q;
  logic                                 ack_q;
  logic                                 err_q;
  logic [DIMENSION-1:0]                 osel_q;
  logic [NUM_OF_IC_SIGNALS-1:0]         ic_q;
  logic                                 rst_mode_q;
  logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0]  pb_q;
  logic [NUM_OF_IC_SIGNALS-1:0]         icsel_q;
  logic [IVAR_WIDTH-1:0]                ivar_q [DIMENSION];

  logic [IVAR_WIDTH-1:0]                ivar_d [DIMENSION];
  logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0]  pb_d;
  logic [PB_WORDS*BUS_WIDTH-1:0]        pb_wide;
  logic [N_W-1:0]                       n_d;
  logic [N_W-1:0]                       run_len;
  logic                                 run_open;
  logic [DIMENSION-1:0]                 osel_word;
  logic [DIMENSION:0]                   osel_ext;
  logic                                 osel_bad;
  logic                                 accept;
  logic                                 last_ivar_word;

  assign accept = (sel == SELECT_WIDTH'(SELECT_ID)) && conf_valid && !ack_q && !rearm;
  assign last_ivar_word = (int'(ivk_q) == int'(n_q) - 1) && (int'(ivp_q) == IVAR_WORDS - 1);

  // Active dimensions = run of ones from bit 0; a valid mask has no holes above it.
  always_comb begin
    osel_word = conf_bus[DIMENSION-1:0];
    osel_ext  = {1'b0, osel_word};
    run_len   = '0;
    run_open  = 1'b1;
    for (int i = 0; i < DIMENSION; i++) begin
      if (run_open && osel_word[i]) begin
        run_len = run_len + N_W'(1);
      end else begin
        run_open = 1'b0;
      end
    end
    n_d      = (run_len == '0) ? N_W'(1) : run_len;
    osel_bad = (osel_word == '0) ||
               ((osel_ext & (osel_ext + {{DIMENSION{1'b0}}, 1'b1})) != '0);
  end

  always_comb begin
    pb_wide = '0;
    pb_wide[MAX_NO_OF_PROGRAM_BLOCKS-1:0] = pb_q;
    pb_wide[int'(pbw_q)*BUS_WIDTH +: BUS_WIDTH] = conf_bus;
    pb_d = pb_wide[MAX_NO_OF_PROGRAM_BLOCKS-1:0];
  end

  generate
    for (genvar gi = 0; gi < DIMENSION; gi++) begin : g_ivar
      logic [IVAR_WORDS*BUS_WIDTH-1:0] ivar_wide;
      always_comb begin
        ivar_wide = '0;
        ivar_wide[IVAR_WIDTH-1:0] = ivar_q[gi];
        ivar_wide[int'(ivp_q)*BUS_WIDTH +: BUS_WIDTH] = conf_bus;
      end
      assign ivar_d[gi] = ivar_wide[IVAR_WIDTH-1:0];
      assign init_ivar[gi*IVAR_WIDTH +: IVAR_WIDTH] = ivar_q[gi];
    end
    for (genvar gi = 0; gi < NUM_OF_IC_SIGNALS; gi++) begin : g_ic
      assign init_ic[gi] = ic_q[gi];
    end
  endgenerate

  always_ff @(posedge conf_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_OSEL;
      pbw_q      <= '0;
      ivp_q      <= '0;
      ivk_q      <= '0;
      n_q        <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      osel_q     <= '0;
      ic_q       <= '0;
      rst_mode_q <= 1'b0;
      pb_q       <= '0;
      icsel_q    <= '0;
      for (int k = 0; k < DIMENSION; k++) ivar_q[k] <= '0;
    end else if (rearm) begin
      state_q <= S_OSEL;
      pbw_q   <= '0;
      ivp_q   <= '0;
      ivk_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      case (state_q)
        S_OSEL: begin
          osel_q  <= osel_word;
          n_q     <= n_d;
          if (osel_bad) err_q <= 1'b1;
          state_q <= S_IC;
        end
        S_IC: begin
          ic_q    <= conf_bus[NUM_OF_IC_SIGNALS-1:0];
          state_q <= S_RST;
        end
        S_RST: begin
          rst_mode_q <= conf_bus[0];
          state_q    <= S_PB;
        end
        S_PB: begin
          pb_q <= pb_d;
          if (int'(pbw_q) == PB_WORDS - 1) begin
            pbw_q   <= '0;
            state_q <= S_ICSEL;
          end else begin
            pbw_q <= pbw_q + PBW_W'(1);
          end
        end
        S_ICSEL: begin
          icsel_q <= conf_bus[NUM_OF_IC_SIGNALS-1:0];
          state_q <= S_IVAR;
        end
        S_IVAR: begin
          for (int k = 0; k < DIMENSION; k++) begin
            if (int'(ivk_q) == k) ivar_q[k] <= ivar_d[k];
          end
          if (last_ivar_word) begin
            ack_q   <= 1'b1;
            ivp_q   <= '0;
            ivk_q   <= '0;
            state_q <= S_DONE;
          end else if (int'(ivp_q) == IVAR_WORDS - 1) begin
            ivp_q <= '0;
            ivk_q <= ivk_q + K_W'(1);
          end else begin
            ivp_q <= ivp_q + IVP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign conf_ack        = ack_q;
  assign conf_error      = err_q;
  assign busy            = (state_q != S_OSEL) && !ack_q;
  assign output_selector = osel_q;
  assign restart_mode    = rst_mode_q;
  assign pb_selector     = pb_q;
  assign ic_selector     = icsel_q;

endmodule

// File: tb/tb_gc_init_loader.sv
// Directed bench for gc_init_loader: default instance plus a wide-ivar /
// wide-program-block instance.
module tb_gc_init_loader;

  logic        conf_clk = 1'b0;
  logic        reset;
  logic [15:0] conf_bus;
  logic        conf_valid;
  logic        conf_valid_w;
  logic [2:0]  sel;
  logic        rearm;

  logic        ack, err, busy, rmode;
  logic [0:47] ivar;
  logic [0:2]  ic;
  logic [2:0]  osel, icsel;
  logic [11:0] pb;

  logic        ack_w, err_w, busy_w, rmode_w;
  logic [0:95] ivar_w;
  logic [0:2]  ic_w;
  logic [2:0]  osel_w, icsel_w;
  logic [19:0] pb_w;

  int checks = 0;
  int failures = 0;

  always #5 conf_clk = ~conf_clk;

  gc_init_loader dut (
    .conf_clk(conf_clk), .reset(reset), .conf_bus(conf_bus), .conf_valid(conf_valid),
    .sel(sel), .rearm(rearm), .conf_ack(ack), .conf_error(err), .busy(busy),
    .init_ivar(ivar), .init_ic(ic), .output_selector(osel), .restart_mode(rmode),
    .pb_selector(pb), .ic_selector(icsel)
  );

  gc_init_loader #(.IVAR_WIDTH(32), .MAX_NO_OF_PROGRAM_BLOCKS(20)) dut_w (
    .conf_clk(conf_clk), .reset(reset), .conf_bus(conf_bus), .conf_valid(conf_valid_w),
    .sel(sel), .rearm(rearm), .conf_ack(ack_w), .conf_error(err_w), .busy(busy_w),
    .init_ivar(ivar_w), .init_ic(ic_w), .output_selector(osel_w), .restart_mode(rmode_w),
    .pb_selector(pb_w), .ic_selector(icsel_w)
  );

  typedef struct {
    logic [2:0]  sel;
    logic        valid;
    logic [15:0] bus;
    logic        exp_ack;
    logic        exp_busy;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // One word on the bus for one edge; samples are taken 1 time unit after it.
  task automatic send(input logic [15:0] w, input bit wide);
    @(negedge conf_clk);
    sel = 3'd2; conf_bus = w; rearm = 1'b0;
    if (wide) conf_valid_w = 1'b1; else conf_valid = 1'b1;
    @(posedge conf_clk); #1;
    conf_valid = 1'b0; conf_valid_w = 1'b0;
  endtask

  task automatic pulse_rearm();
    @(negedge conf_clk);
    rearm = 1'b1; conf_valid = 1'b0;
    @(posedge conf_clk); #1;
    rearm = 1'b0;
  endtask

  task automatic load(input logic [15:0] words [], input string tag);
    for (int i = 0; i < words.size(); i++) begin
      send(words[i], 1'b0);
      chk($sformatf("%s_ack%0d", tag, i), {127'd0, ack}, {127'd0, i == words.size() - 1});
    end
  endtask

  initial begin
    logic [15:0] s1 [];
    logic [15:0] s2 [];
    logic [15:0] s3 [];
    logic [15:0] s6 [];
    logic [15:0] sw [];
    s1 = '{16'h0007, 16'h0005, 16'h0001, 16'h0A5A, 16'h0003, 16'hFFFE, 16'h0010, 16'h8000};
    s2 = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4321};
    s3 = '{16'h0005, 16'h0007, 16'h0001, 16'h0FFF, 16'h0007, 16'h2222};
    s6 = '{16'h0003, 16'h0002, 16'h0000, 16'h0123, 16'h0001, 16'hAAAA, 16'hBBBB};
    sw = '{16'h0003, 16'h0005, 16'h0001, 16'hFFFF, 16'h00FF, 16'h0006,
           16'h5678, 16'h1234, 16'hBEEF, 16'hDEAD};

    tbl[0]  = '{3'd2, 1'b1, 16'h0007, 1'b0, 1'b1};
    tbl[1]  = '{3'd2, 1'b0, 16'h1234, 1'b0, 1'b1};
    tbl[2]  = '{3'd3, 1'b1, 16'h0002, 1'b0, 1'b1};
    tbl[3]  = '{3'd2, 1'b1, 16'h0005, 1'b0, 1'b1};
    tbl[4]  = '{3'd2, 1'b1, 16'h0001, 1'b0, 1'b1};
    tbl[5]  = '{3'd2, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[6]  = '{3'd2, 1'b1, 16'h0A5A, 1'b0, 1'b1};
    tbl[7]  = '{3'd3, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    tbl[8]  = '{3'd2, 1'b1, 16'h0003, 1'b0, 1'b1};
    tbl[9]  = '{3'd2, 1'b1, 16'hFFFE, 1'b0, 1'b1};
    tbl[10] = '{3'd2, 1'b1, 16'h0010, 1'b0, 1'b1};
    tbl[11] = '{3'd2, 1'b0, 16'h7777, 1'b0, 1'b1};
    tbl[12] = '{3'd2, 1'b1, 16'h8000, 1'b1, 1'b0};
    tbl[13] = '{3'd2, 1'b1, 16'h1111, 1'b1, 1'b0};
    tbl[14] = '{3'd2, 1'b1, 16'h2222, 1'b1, 1'b0};

    reset = 1'b1; conf_bus = '0; conf_valid = 1'b0; conf_valid_w = 1'b0;
    sel = 3'd0; rearm = 1'b0;
    #2;
    chk("rst_ack", {127'd0, ack}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_ivar", {80'd0, ivar}, 128'd0);
    chk("rst_pb", {116'd0, pb}, 128'd0);
    @(negedge conf_clk); reset = 1'b0;

    // Defaults, one word per cycle.
    load(s1, "s1");
    chk("s1_busy", {127'd0, busy}, 128'd0);
    chk("s1_osel", {125'd0, osel}, 128'h7);
    chk("s1_ic", {125'd0, ic}, 128'h5);
    chk("s1_rmode", {127'd0, rmode}, 128'd1);
    chk("s1_pb", {116'd0, pb}, 128'hA5A);
    chk("s1_icsel", {125'd0, icsel}, 128'h3);
    chk("s1_ivar", {80'd0, ivar}, 128'hFFFE_0010_8000);
    chk("s1_err", {127'd0, err}, 128'd0);

    // Single active dimension: six words, other ivars retained.
    pulse_rearm();
    chk("s2_rearm_ack", {127'd0, ack}, 128'd0);
    load(s2, "s2");
    chk("s2_ivar", {80'd0, ivar}, 128'h4321_0010_8000);
    chk("s2_err", {127'd0, err}, 128'd0);

    // Non-thermometer selector: sticky error, N=1.
    pulse_rearm();
    load(s3, "s3");
    chk("s3_err", {127'd0, err}, 128'd1);
    chk("s3_osel", {125'd0, osel}, 128'h5);
    chk("s3_ivar", {80'd0, ivar}, 128'h2222_0010_8000);
    chk("s3_pb", {116'd0, pb}, 128'hFFF);
    pulse_rearm();
    chk("s3_rearm_err", {127'd0, err}, 128'd0);
    chk("s3_rearm_busy", {127'd0, busy}, 128'd0);

    // Gaps and foreign selects, then words after ack.
    for (int i = 0; i < 15; i++) begin
      @(negedge conf_clk);
      sel = tbl[i].sel; conf_valid = tbl[i].valid; conf_bus = tbl[i].bus; rearm = 1'b0;
      @(posedge conf_clk); #1;
      conf_valid = 1'b0;
      chk($sformatf("tbl%0d_ack", i), {127'd0, ack}, {127'd0, tbl[i].exp_ack});
      chk($sformatf("tbl%0d_busy", i), {127'd0, busy}, {127'd0, tbl[i].exp_busy});
    end
    chk("tbl_osel", {125'd0, osel}, 128'h7);
    chk("tbl_ic", {125'd0, ic}, 128'h5);
    chk("tbl_rmode", {127'd0, rmode}, 128'd1);
    chk("tbl_pb", {116'd0, pb}, 128'hA5A);
    chk("tbl_icsel", {125'd0, icsel}, 128'h3);
    chk("tbl_ivar", {80'd0, ivar}, 128'hFFFE_0010_8000);

    // Rearm with a concurrent word in S_PB: the word is dropped.
    pulse_rearm();
    send(16'h0007, 1'b0);
    send(16'h0005, 1'b0);
    send(16'h0001, 1'b0);
    @(negedge conf_clk);
    rearm = 1'b1; conf_valid = 1'b1; sel = 3'd2; conf_bus = 16'h0FFF;
    @(posedge conf_clk); #1;
    rearm = 1'b0; conf_valid = 1'b0;
    chk("s6_ack", {127'd0, ack}, 128'd0);
    chk("s6_err", {127'd0, err}, 128'd0);
    chk("s6_busy", {127'd0, busy}, 128'd0);
    chk("s6_pb_kept", {116'd0, pb}, 128'hA5A);
    load(s6, "s6");
    chk("s6_ivar", {80'd0, ivar}, 128'hAAAA_BBBB_8000);
    chk("s6_ic", {125'd0, ic}, 128'h2);
    chk("s6_rmode", {127'd0, rmode}, 128'd0);
    chk("s6_pb", {116'd0, pb}, 128'h123);
    chk("s6_icsel", {125'd0, icsel}, 128'h1);
    chk("s6_osel", {125'd0, osel}, 128'h3);

    // Asynchronous reset in the middle of S_IVAR.
    pulse_rearm();
    send(16'h0007, 1'b0);
    send(16'h0005, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0A5A, 1'b0);
    send(16'h0003, 1'b0);
    send(16'h1234, 1'b0);
    chk("mid_busy", {127'd0, busy}, 128'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ivar", {80'd0, ivar}, 128'd0);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_osel", {125'd0, osel}, 128'd0);
    chk("mid_rst_pb", {116'd0, pb}, 128'd0);
    chk("mid_rst_rmode", {127'd0, rmode}, 128'd0);
    @(negedge conf_clk); reset = 1'b0;

    // Wide instance: two PB words, two words per ivar.
    for (int i = 0; i < sw.size(); i++) begin
      send(sw[i], 1'b1);
      chk($sformatf("w_ack%0d", i), {127'd0, ack_w}, {127'd0, i == sw.size() - 1});
    end
    chk("w_pb", {108'd0, pb_w}, 128'hFFFFF);
    chk("w_icsel", {125'd0, icsel_w}, 128'h6);
    chk("w_ivar", {32'd0, ivar_w}, 128'h12345678_DEADBEEF_00000000);
    chk("w_osel", {125'd0, osel_w}, 128'h3);
    chk("w_err", {127'd0, err_w}, 128'd0);
    chk("w_dflt_ack", {127'd0, ack}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
